// File: rtl/encode.sv
// RISC-V instruction word encoder with a single-entry registered output and
// LI pseudo-op expansion. Optional immediate range checking: ENCODE_IMM_CHECK_EN.
module encode (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_kind,
    input  logic [4:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_f3,
    input  logic [6:0]  in_f7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_last,
    output logic        out_err
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned HI_W   = 20;
    localparam logic [6:0]  OP_LUI  = 7'b0110111;
    localparam logic [6:0]  OP_ADDI = 7'b0010011;
    localparam logic [31:0] LI_RND  = 32'h0000_0800;

    typedef enum logic [2:0] {
        K_R  = 3'd0,
        K_I  = 3'd1,
        K_S  = 3'd2,
        K_B  = 3'd3,
        K_U  = 3'd4,
        K_J  = 3'd5,
        K_LI = 3'd6,
        K_RX = 3'd7
    } kind_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONE  = 2'd1,
        HI   = 2'd2,
        LO   = 2'd3
    } state_e;

    state_e            state, state_nx;
    logic [XLEN-1:0]   pend_inst, pend_nx;
    logic              valid_nx, last_nx, err_nx;
    logic [XLEN-1:0]   inst_nx;

    logic [XLEN-1:0]   enc_inst, enc_pend;
    logic              enc_last, enc_two, enc_err;
    logic [6:0]        opc;
    logic [XLEN-1:0]   li_sum;
    logic [HI_W-1:0]   li_hi;
    logic              fits12;
    logic              accept, drain;

    assign opc    = {in_opcode, 2'b11};
    assign li_sum = in_imm + LI_RND;
    assign li_hi  = li_sum[XLEN-1:XLEN-HI_W];
    assign fits12 = (in_imm[31:11] == 21'h0) || (in_imm[31:11] == {21{1'b1}});

`ifdef ENCODE_IMM_CHECK_EN
    logic fits13, fits21;
    assign fits13 = (in_imm[31:12] == 20'h0) || (in_imm[31:12] == {20{1'b1}});
    assign fits21 = (in_imm[31:20] == 12'h0) || (in_imm[31:20] == {12{1'b1}});
`endif

    // Accept only when nothing is pending behind the held word and the held word can leave.
    assign in_ready = !rst && (state != HI) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    // Field packing for the current request.
    always_comb begin
        enc_inst = '0;
        enc_pend = '0;
        enc_last = 1'b1;
        enc_two  = 1'b0;
        enc_err  = 1'b0;
        case (in_kind)
            K_I: enc_inst = {in_imm[11:0], in_rs1, in_f3, in_rd, opc};
            K_S: enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_f3, in_imm[4:0], opc};
            K_B: enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_f3,
                             in_imm[4:1], in_imm[11], opc};
            K_U: enc_inst = {in_imm[31:12], in_rd, opc};
            K_J: enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
            K_LI: begin
                if (fits12) begin
                    enc_inst = {in_imm[11:0], 5'd0, 3'd0, in_rd, OP_ADDI};
                end else begin
                    enc_inst = {li_hi, in_rd, OP_LUI};
                    // A zero low part needs no ADDI; LUI alone is the final word.
                    if (in_imm[11:0] != 12'h0) begin
                        enc_last = 1'b0;
                        enc_two  = 1'b1;
                        enc_pend = {in_imm[11:0], in_rd, 3'd0, in_rd, OP_ADDI};
                    end
                end
            end
            default: enc_inst = {in_f7, in_rs2, in_rs1, in_f3, in_rd, opc};
        endcase
`ifdef ENCODE_IMM_CHECK_EN
        case (in_kind)
            K_I, K_S: enc_err = !fits12;
            K_B:      enc_err = !fits13 || in_imm[0];
            K_U:      enc_err = (in_imm[11:0] != 12'h0);
            K_J:      enc_err = !fits21 || in_imm[0];
            default:  enc_err = 1'b0;
        endcase
`endif
    end

    // Next-state and next-output selection.
    always_comb begin
        state_nx = state;
        valid_nx = out_valid;
        inst_nx  = out_inst;
        last_nx  = out_last;
        err_nx   = out_err;
        pend_nx  = pend_inst;
        case (state)
            HI: begin
                if (drain) begin
                    inst_nx  = pend_inst;
                    last_nx  = 1'b1;
                    err_nx   = 1'b0;
                    state_nx = LO;
                end
            end
            default: begin
                if (accept) begin
                    valid_nx = 1'b1;
                    inst_nx  = enc_inst;
                    last_nx  = enc_last;
                    err_nx   = enc_err;
                    pend_nx  = enc_pend;
                    state_nx = enc_two ? HI : ONE;
                end else if (drain) begin
                    valid_nx = 1'b0;
                    state_nx = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
            pend_inst <= '0;
        end else begin
            state     <= state_nx;
            out_valid <= valid_nx;
            out_inst  <= inst_nx;
            out_last  <= last_nx;
            out_err   <= err_nx;
            pend_inst <= pend_nx;
        end
    end

endmodule

// File: tb/tb_encode.sv
// Scoreboard bench for encode: expected words queued at stimulus time, popped on each output transfer.
module tb_encode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_kind = '0;
    logic [4:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_f3 = '0;
    logic [6:0]  in_f7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic        out_last;
    logic        out_err;

    typedef struct packed {
        logic [31:0] inst;
        logic        last;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   rand_ready = 1'b0;

    encode dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_f3(in_f3), .in_f7(in_f7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_last(out_last), .out_err(out_err)
    );

    always #5 clk = ~clk;

    // Reference encoder built bit-field by bit-field.
    function automatic void model(input logic [2:0] k, input logic [4:0] op, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic [31:0] imm,
                                  output int n, output exp_t e0, output exp_t e1);
        logic [31:0] w;
        logic [31:0] hi;
        int si;
        si = int'($signed(imm));
        w = '0;
        w[1:0] = 2'b11;
        w[6:2] = op;
        n = 1;
        e0 = '0;
        e1 = '0;
        e0.last = 1'b1;
        case (k)
            3'd1: begin
                w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1; w[31:20] = imm[11:0];
                e0.err = (si < -2048) || (si > 2047);
            end
            3'd2: begin
                w[11:7] = imm[4:0]; w[14:12] = f3; w[19:15] = rs1; w[24:20] = rs2;
                w[31:25] = imm[11:5];
                e0.err = (si < -2048) || (si > 2047);
            end
            3'd3: begin
                w[7] = imm[11]; w[11:8] = imm[4:1]; w[14:12] = f3; w[19:15] = rs1;
                w[24:20] = rs2; w[30:25] = imm[10:5]; w[31] = imm[12];
                e0.err = (si < -4096) || (si > 4095) || imm[0];
            end
            3'd4: begin
                w[11:7] = rd; w[31:12] = imm[31:12];
                e0.err = (imm[11:0] != 12'h0);
            end
            3'd5: begin
                w[11:7] = rd; w[19:12] = imm[19:12]; w[20] = imm[11];
                w[30:21] = imm[10:1]; w[31] = imm[20];
                e0.err = (si < -1048576) || (si > 1048575) || imm[0];
            end
            3'd6: begin
                if (si >= -2048 && si <= 2047) begin
                    w[6:0] = 7'h13; w[11:7] = rd; w[31:20] = imm[11:0];
                end else begin
                    hi = imm + 32'h800;
                    w[6:0] = 7'h37; w[11:7] = rd; w[31:12] = hi[31:12];
                    if (imm[11:0] != 12'h0) begin
                        n = 2;
                        e0.last = 1'b0;
                        e1.inst = 32'h13 | (32'(rd) << 7) | (32'(rd) << 15) | (32'(imm[11:0]) << 20);
                        e1.last = 1'b1;
                    end
                end
            end
            default: begin
                w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1; w[24:20] = rs2; w[31:25] = f7;
            end
        endcase
`ifndef ENCODE_IMM_CHECK_EN
        e0.err = 1'b0;
`endif
        e0.inst = w;
    endfunction

    // Queue expectations, present a request, and wait (bounded) until it is accepted.
    task automatic send(input logic [2:0] k, input logic [4:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
        int n;
        exp_t e0, e1;
        bit acc;
        model(k, op, rd, rs1, rs2, f3, f7, imm, n, e0, e1);
        sb.push_back(e0);
        if (n == 2) sb.push_back(e1);
        in_valid = 1'b1; in_kind = k; in_opcode = op; in_rd = rd; in_rs1 = rs1;
        in_rs2 = rs2; in_f3 = f3; in_f7 = f7; in_imm = imm;
        acc = 1'b0;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL send_accept: accepted=%b required=1 (kind=%0d imm=%h)", acc, k, imm);
        end
    endtask

    // Output monitor: every transfer must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got inst=%h last=%b err=%b, required none",
                             out_inst, out_last, out_err);
                end else begin
                    e = sb.pop_front();
                    if ({out_inst, out_last, out_err} !== {e.inst, e.last, e.err}) begin
                        errors++;
                        $display("FAIL word: got inst=%h last=%b err=%b, required inst=%h last=%b err=%b",
                                 out_inst, out_last, out_err, e.inst, e.last, e.err);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", out_valid); end
        if (out_inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h required 0", out_inst); end
        if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b required 0", out_last); end
        if (out_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", out_err); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b required 1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_spec_vectors;
        out_ready = 1'b1;
        send(3'd1, 5'h04, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL i_latency: valid=%b required 1", out_valid); end
        if (out_inst !== 32'h00500093) begin errors++; $display("FAIL i_word: got %h required 00500093", out_inst); end
        send(3'd4, 5'h0D, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        checks++;
        if (out_inst !== 32'h123452B7) begin errors++; $display("FAIL u_word: got %h required 123452b7", out_inst); end
        send(3'd6, 5'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345678);
        checks += 3;
        if (out_inst !== 32'h12345537) begin errors++; $display("FAIL li_lui: got %h required 12345537", out_inst); end
        if (out_last !== 1'b0) begin errors++; $display("FAIL li_lui_last: got %b required 0", out_last); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL li_in_ready: got %b required 0", in_ready); end
        @(posedge clk);
        #1;
        checks += 2;
        if (out_inst !== 32'h67850513) begin errors++; $display("FAIL li_addi: got %h required 67850513", out_inst); end
        if (out_last !== 1'b1) begin errors++; $display("FAIL li_addi_last: got %b required 1", out_last); end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL li_drained: valid=%b required 0", out_valid); end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        send(3'd6, 5'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800);
        in_imm = 32'hDEADBEEF;
        in_rd  = 5'd3;
        in_kind = 3'd0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({out_valid, out_inst, out_last} !== {1'b1, 32'h00001537, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold%0d: got valid=%b inst=%h last=%b required 1/00001537/0",
                         i, out_valid, out_inst, out_last);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({out_inst, out_last} !== {32'h80050513, 1'b1}) begin
            errors++;
            $display("FAIL stall_addi: got inst=%h last=%b required 80050513/1", out_inst, out_last);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_imm_err;
        logic exp_err;
`ifdef ENCODE_IMM_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        out_ready = 1'b1;
        send(3'd3, 5'h18, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4097);
        checks++;
        if (out_err !== exp_err) begin errors++; $display("FAIL b_range_err: got %b required %b", out_err, exp_err); end
        send(3'd5, 5'h1B, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF00000);
        checks++;
        if (out_err !== 1'b0) begin errors++; $display("FAIL j_min_err: got %b required 0", out_err); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_li;
        out_ready = 1'b0;
        send(3'd6, 5'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345678);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_li_held: valid=%b required 1", out_valid); end
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_li_valid: got %b required 0", out_valid); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_li_in_ready: got %b required 0", in_ready); end
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_li_idle: in_ready=%b required 1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_li_no_addi%0d: valid=%b required 0", i, out_valid); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] imm;
        logic [11:0] r12;
        logic [12:0] r13;
        int guard;
        rand_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            r12 = 12'($urandom);
            r13 = 13'($urandom);
            case ($urandom_range(0, 3))
                0: imm = {{20{r12[11]}}, r12};
                1: imm = $urandom;
                2: imm = {{19{r13[12]}}, r13[12:1], 1'b0};
                default: imm = {20'($urandom), 12'h0};
            endcase
            send(3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 3'($urandom), 7'($urandom), imm);
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        #1;
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL drain_timeout: %0d words pending, required 0", sb.size()); end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset;
        test_spec_vectors;
        test_backpressure;
        test_imm_err;
        test_reset_mid_li;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
